// File: rtl/bpm_estimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bpm_estimator: times beat-to-beat intervals, averages the last AVG_DEPTH    |
// | accepted ones and converts the average to a rounded, clamped BPM value.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module bpm_estimator #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned MAX_BPM   = 200,
    parameter int unsigned MIN_BPM   = 40,
    parameter int unsigned AVG_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           beat_pulse,
    output logic [$clog2(MAX_BPM+1)-1:0]   BPM_estimate,
    output logic                           bpm_valid,
    output logic                           locked
);

    localparam longint unsigned C_K64     = 64'd60 * 64'(CLK_HZ);
    localparam longint unsigned C_MIN_INT = C_K64 / 64'(MAX_BPM);
    localparam longint unsigned C_MAX_INT = C_K64 / 64'(MIN_BPM);
    localparam int C_INT_W = $clog2(C_MAX_INT + 1);
    localparam int C_NUM_W = $clog2(C_K64 * AVG_DEPTH + AVG_DEPTH * C_MAX_INT / 2 + 1);
    localparam int C_OUT_W = $clog2(MAX_BPM + 1);
    localparam int C_N_W   = $clog2(AVG_DEPTH + 1);
    localparam int C_SUM_W = C_INT_W + C_N_W;
    localparam int C_PTR_W = (AVG_DEPTH > 1) ? $clog2(AVG_DEPTH) : 1;
    localparam int C_BIT_W = $clog2(C_NUM_W);

    localparam logic [C_INT_W-1:0] C_MIN_INT_V = C_INT_W'(C_MIN_INT);
    localparam logic [C_INT_W-1:0] C_MAX_INT_V = C_INT_W'(C_MAX_INT);
    localparam logic [C_NUM_W-1:0] C_K_V       = C_NUM_W'(C_K64);
    localparam logic [C_N_W-1:0]   C_N_MAX     = C_N_W'(AVG_DEPTH);
    localparam logic [C_PTR_W-1:0] C_PTR_LAST  = C_PTR_W'(AVG_DEPTH - 1);

    typedef enum logic {
        TRK_IDLE   = 1'b0,
        TRK_ACTIVE = 1'b1
    } trk_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_t;

    trk_t                 trk_q, trk_d;
    div_t                 div_q, div_d;
    logic [C_INT_W-1:0]   cnt_q, cnt_d;
    logic [C_INT_W-1:0]   hist_q [AVG_DEPTH];
    logic [C_PTR_W-1:0]   wp_q, wp_d;
    logic [C_SUM_W-1:0]   sum_q, sum_d;
    logic [C_N_W-1:0]     n_q, n_d;
    logic                 pend_q, pend_d;
    logic [C_SUM_W-1:0]   rem_q, rem_d;
    logic [C_NUM_W-1:0]   quo_q, quo_d;
    logic [C_SUM_W-1:0]   den_q, den_d;
    logic [C_BIT_W-1:0]   bit_q, bit_d;
    logic [C_OUT_W-1:0]   bpm_q, bpm_d;
    logic                 valid_q, valid_d;

    logic                 w_arm, w_accept, w_timeout, w_ge;
    logic [C_SUM_W:0]     w_rem_sh;
    logic [C_SUM_W-1:0]   w_rem_sub;
    logic [C_NUM_W-1:0]   w_quo_sh;
    logic [C_NUM_W-1:0]   w_num;
    logic [C_SUM_W-1:0]   w_sum_new;

    assign w_arm     = (trk_q == TRK_IDLE) && beat_pulse;
    assign w_accept  = (trk_q == TRK_ACTIVE) && beat_pulse && (cnt_q >= C_MIN_INT_V);
    assign w_timeout = (trk_q == TRK_ACTIVE) && !beat_pulse && (cnt_q == C_MAX_INT_V);

    // The evicted slot is zero until history fills, so one expression covers both cases.
    assign w_sum_new = sum_q + C_SUM_W'(cnt_q) - C_SUM_W'(hist_q[wp_q]);

    // Adding sum/2 to the numerator turns truncating division into round-half-up.
    assign w_num     = C_K_V * C_NUM_W'(n_q) + C_NUM_W'(sum_q >> 1);

    assign w_rem_sh  = {rem_q, quo_q[C_NUM_W-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, den_q});
    assign w_rem_sub = w_rem_sh[C_SUM_W-1:0] - den_q;
    assign w_quo_sh  = {quo_q[C_NUM_W-2:0], w_ge};

    always_comb begin
        trk_d   = trk_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        wp_d    = wp_q;
        sum_d   = sum_q;
        n_d     = n_q;
        pend_d  = pend_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        bit_d   = bit_q;
        bpm_d   = bpm_q;
        valid_d = 1'b0;

        if (w_arm) begin
            trk_d = TRK_ACTIVE;
            cnt_d = C_INT_W'(1);
        end else if (w_accept) begin
            cnt_d  = C_INT_W'(1);
            wp_d   = (wp_q == C_PTR_LAST) ? '0 : wp_q + C_PTR_W'(1);
            sum_d  = w_sum_new;
            n_d    = (n_q == C_N_MAX) ? n_q : n_q + C_N_W'(1);
            pend_d = 1'b1;
        end else if (w_timeout) begin
            trk_d = TRK_IDLE;
            cnt_d = '0;
            wp_d  = '0;
            sum_d = '0;
            n_d   = '0;
        end else if ((trk_q == TRK_ACTIVE) && (cnt_q != C_MAX_INT_V)) begin
            cnt_d = cnt_q + C_INT_W'(1);
        end

        case (div_q)
            DIV_IDLE: begin
                if (pend_q && (n_q != '0)) begin
                    rem_d  = '0;
                    quo_d  = w_num;
                    den_d  = sum_q;
                    bit_d  = C_BIT_W'(C_NUM_W - 1);
                    div_d  = DIV_RUN;
                    pend_d = w_accept;
                end
            end
            DIV_RUN: begin
                rem_d = w_ge ? w_rem_sub : w_rem_sh[C_SUM_W-1:0];
                quo_d = w_quo_sh;
                bit_d = bit_q - C_BIT_W'(1);
                if (bit_q == '0) begin
                    div_d   = DIV_DONE;
                    bpm_d   = (w_quo_sh > C_NUM_W'(MAX_BPM)) ? C_OUT_W'(MAX_BPM)
                                                             : w_quo_sh[C_OUT_W-1:0];
                    valid_d = 1'b1;
                end
            end
            DIV_DONE: div_d = DIV_IDLE;
            default:  div_d = DIV_IDLE;
        endcase

        // Timeout overrides any divide result landing in the same cycle.
        if (w_timeout) begin
            div_d   = DIV_IDLE;
            pend_d  = 1'b0;
            bpm_d   = '0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk_q   <= TRK_IDLE;
            div_q   <= DIV_IDLE;
            cnt_q   <= '0;
            wp_q    <= '0;
            sum_q   <= '0;
            n_q     <= '0;
            pend_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            bit_q   <= '0;
            bpm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            trk_q   <= trk_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            sum_q   <= sum_d;
            n_q     <= n_d;
            pend_q  <= pend_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            bit_q   <= bit_d;
            bpm_q   <= bpm_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
        end else if (w_timeout) begin
            for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
        end else if (w_accept) begin
            hist_q[wp_q] <= cnt_q;
        end
    end

    assign BPM_estimate = bpm_q;
    assign bpm_valid    = valid_q;
    assign locked       = (n_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_bpm_estimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bpm_estimator: randomized and directed checks of bpm_estimator against   |
// | an event-level tempo model. Revision: 1.0                                   |
// +----------------------------------------------------------------------------+
module tb_bpm_estimator;

    localparam int K       = 60 * 1000;
    localparam int MAX_BPM = 200;
    localparam int MIN_INT = 300;
    localparam int MAX_INT = 1500;
    localparam int DEPTH   = 4;
    localparam int NUM_W   = 18;

    typedef struct {
        int c;
        int v;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       beat_pulse;
    logic [7:0] BPM_estimate;
    logic       bpm_valid;
    logic       locked;
    logic       f_beat;
    logic [7:0] f_bpm;
    logic       f_valid;
    logic       f_locked;

    int total = 0;
    int bad   = 0;

    // model state
    int  cyc, m_last, m_s, m_res, m_bpm;
    bit  m_armed, m_pend, m_busy, m_valid, m_locked;
    int  m_ivals[$];
    ev_t obs_q[$];
    ev_t exp_q[$];
    int  beat_cyc[$];
    int  prev_bpm, hold_bad, lock_bad;

    bpm_estimator #(.CLK_HZ(1000), .MAX_BPM(200), .MIN_BPM(40), .AVG_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .beat_pulse(beat_pulse),
        .BPM_estimate(BPM_estimate), .bpm_valid(bpm_valid), .locked(locked)
    );

    bpm_estimator #(.CLK_HZ(10), .MAX_BPM(200), .MIN_BPM(10), .AVG_DEPTH(4)) u_fast (
        .clk(clk), .reset(reset), .beat_pulse(f_beat),
        .BPM_estimate(f_bpm), .bpm_valid(f_valid), .locked(f_locked)
    );

    always #5 clk = ~clk;

    function automatic int expect_bpm(input int q[$]);
        int s, r;
        s = 0;
        foreach (q[i]) s += q[i];
        r = (K * q.size() + s / 2) / s;
        return (r > MAX_BPM) ? MAX_BPM : r;
    endfunction

    task automatic model_reset();
        cyc = 0; m_last = 0; m_s = 0; m_res = 0; m_bpm = 0;
        m_armed = 0; m_pend = 0; m_busy = 0; m_valid = 0; m_locked = 0;
        m_ivals.delete();
        prev_bpm = 0;
    endtask

    // Advances the model by one cycle in which the beat input equals 'beat'.
    task automatic model_next(input bit beat);
        int nbpm, d;
        bit nv, idle;
        nbpm = m_bpm; nv = 0; idle = !m_busy;
        if (m_busy && cyc == m_s + NUM_W) begin nbpm = m_res; nv = 1; end
        if (m_busy && cyc == m_s + NUM_W + 1) m_busy = 0;
        if (idle && m_pend) begin
            m_res = expect_bpm(m_ivals); m_s = cyc; m_busy = 1; m_pend = 0;
        end
        if (!m_armed) begin
            if (beat) begin m_armed = 1; m_last = cyc; end
        end else begin
            d = cyc - m_last;
            if (beat && d >= MIN_INT) begin
                m_ivals.push_back(d);
                if (m_ivals.size() > DEPTH) void'(m_ivals.pop_front());
                m_pend = 1; m_last = cyc;
            end else if (!beat && d >= MAX_INT) begin
                m_ivals.delete(); m_armed = 0; m_pend = 0; m_busy = 0;
                nbpm = 0; nv = 1;
            end
        end
        m_bpm = nbpm; m_valid = nv; m_locked = (m_ivals.size() > 0); cyc++;
    endtask

    task automatic step(input bit beat);
        ev_t e;
        beat_pulse = beat;
        if (beat) beat_cyc.push_back(cyc);
        model_next(beat);
        @(posedge clk); #1;
        beat_pulse = 1'b0;
        if (bpm_valid === 1'b1) begin
            e.c = cyc; e.v = int'(BPM_estimate); obs_q.push_back(e);
        end else if (int'(BPM_estimate) != prev_bpm) hold_bad++;
        prev_bpm = int'(BPM_estimate);
        if (m_valid) begin e.c = cyc; e.v = m_bpm; exp_q.push_back(e); end
        if (locked !== m_locked) lock_bad++;
    endtask

    task automatic run_beats(input int gaps[$], input int tail);
        obs_q.delete(); exp_q.delete(); beat_cyc.delete();
        hold_bad = 0; lock_bad = 0;
        step(1'b1);
        foreach (gaps[i]) begin
            repeat (gaps[i] - 1) step(1'b0);
            step(1'b1);
        end
        repeat (tail) step(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; beat_pulse = 1'b0; f_beat = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int g[$];
        reset = 1'b1; beat_pulse = 1'b0; f_beat = 1'b0;
        #3;
        total++; if (BPM_estimate !== 8'd0) begin bad++; $display("FAIL reset_bpm: got %0d expected 0", BPM_estimate); end
        total++; if (bpm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bpm_valid); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b expected 0", locked); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        g = {};
        run_beats(g, 10);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL reset_idle_pulses: got %0d expected 0", obs_q.size()); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_idle_locked: got %b expected 0", locked); end
    endtask

    task automatic test_steady();
        int g[$];
        do_reset();
        g = '{500, 500, 500, 500, 500};
        run_beats(g, 30);
        total++; if (obs_q.size() != exp_q.size() || obs_q.size() != 5) begin bad++; $display("FAIL steady_count: got %0d expected 5 (model %0d)", obs_q.size(), exp_q.size()); end
        foreach (obs_q[i]) begin
            total++; if (obs_q[i].v != 120) begin bad++; $display("FAIL steady_val[%0d]: got %0d expected 120", i, obs_q[i].v); end
        end
        if (obs_q.size() > 0) begin
            total++; if (obs_q[0].c != beat_cyc[1] + 20) begin bad++; $display("FAIL steady_latency: got %0d expected %0d", obs_q[0].c - beat_cyc[1], 20); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL steady_locked: got %b expected 1", locked); end
        total++; if (hold_bad != 0 || lock_bad != 0) begin bad++; $display("FAIL steady_hold: got hold=%0d lock=%0d expected 0", hold_bad, lock_bad); end
    endtask

    task automatic test_averaging();
        int g[$];
        int lit[4] = '{150, 120, 120, 120};
        do_reset();
        g = '{400, 600, 500, 500};
        run_beats(g, 30);
        total++; if (obs_q.size() != 4) begin bad++; $display("FAIL avg_count: got %0d expected 4", obs_q.size()); end
        foreach (lit[i]) begin
            total++;
            if (i >= obs_q.size() || obs_q[i].v != lit[i]) begin
                bad++; $display("FAIL avg_val[%0d]: got %0d expected %0d", i, (i < obs_q.size()) ? obs_q[i].v : -1, lit[i]);
            end
        end
    endtask

    task automatic test_debounce();
        int g[$];
        do_reset();
        g = '{500, 150, 350};
        run_beats(g, 30);
        total++; if (obs_q.size() != 2) begin bad++; $display("FAIL debounce_count: got %0d expected 2", obs_q.size()); end
        foreach (obs_q[i]) begin
            total++; if (obs_q[i].v != 120) begin bad++; $display("FAIL debounce_val[%0d]: got %0d expected 120", i, obs_q[i].v); end
        end
    endtask

    task automatic test_boundary();
        int g[$];
        do_reset();
        g = '{300};
        run_beats(g, 30);
        total++; if (obs_q.size() != 1 || obs_q[0].v != 200) begin bad++; $display("FAIL bound_min_int: got n=%0d v=%0d expected one pulse of 200", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].v : -1); end
        do_reset();
        g = '{1500};
        run_beats(g, 30);
        total++; if (obs_q.size() != 1 || obs_q[0].v != 40) begin bad++; $display("FAIL bound_max_int: got n=%0d v=%0d expected one pulse of 40", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].v : -1); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL bound_locked: got %b expected 1", locked); end
    endtask

    task automatic test_timeout();
        int g[$];
        do_reset();
        g = '{500};
        run_beats(g, 1510);
        total++; if (obs_q.size() != 2) begin bad++; $display("FAIL timeout_count: got %0d expected 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            total++; if (obs_q[1].v != 0 || obs_q[1].c != beat_cyc[1] + 1501) begin bad++; $display("FAIL timeout_pulse: got v=%0d at +%0d expected 0 at +1501", obs_q[1].v, obs_q[1].c - beat_cyc[1]); end
        end
        total++; if (locked !== 1'b0 || BPM_estimate !== 8'd0) begin bad++; $display("FAIL timeout_state: got locked=%b bpm=%0d expected 0/0", locked, BPM_estimate); end
        g = '{500};
        run_beats(g, 30);
        total++; if (obs_q.size() != 1 || obs_q[0].v != 120) begin bad++; $display("FAIL timeout_rearm: got n=%0d v=%0d expected one pulse of 120", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].v : -1); end
    endtask

    task automatic test_overlap();
        int vals[$];
        int cycs[$];
        do_reset();
        for (int c = 0; c < 70; c++) begin
            f_beat = (c == 0 || c == 10 || c == 14 || c == 18);
            @(posedge clk); #1;
            f_beat = 1'b0;
            if (f_valid === 1'b1) begin vals.push_back(int'(f_bpm)); cycs.push_back(c + 1); end
        end
        total++; if (vals.size() != 2) begin bad++; $display("FAIL overlap_count: got %0d expected 2", vals.size()); end
        if (vals.size() == 2) begin
            total++; if (vals[0] != 60 || cycs[0] != 24) begin bad++; $display("FAIL overlap_first: got %0d at %0d expected 60 at 24", vals[0], cycs[0]); end
            total++; if (vals[1] != 100) begin bad++; $display("FAIL overlap_latest_sum: got %0d expected 100", vals[1]); end
        end
    endtask

    task automatic test_reset_mid_divide();
        int g[$];
        do_reset();
        g = '{500, 500};
        run_beats(g, 0);
        repeat (8) step(1'b0);
        total++; if (BPM_estimate !== 8'd120 || locked !== 1'b1) begin bad++; $display("FAIL middiv_before: got bpm=%0d locked=%b expected 120/1", BPM_estimate, locked); end
        reset = 1'b1;
        #2;
        total++; if (BPM_estimate !== 8'd0 || bpm_valid !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL middiv_async: got bpm=%0d valid=%b locked=%b expected 0/0/0", BPM_estimate, bpm_valid, locked); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        g = {};
        obs_q.delete(); exp_q.delete();
        repeat (40) step(1'b0);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL middiv_no_pulse: got %0d pulses expected 0", obs_q.size()); end
    endtask

    task automatic test_random();
        int g[$];
        int r;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      g.push_back(int'($urandom_range(50, 299)));
            else if (r < 9) g.push_back(int'($urandom_range(300, 1500)));
            else            g.push_back(int'($urandom_range(1501, 1700)));
        end
        run_beats(g, 40);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= obs_q.size() || obs_q[i].v != exp_q[i].v || obs_q[i].c != exp_q[i].c) begin
                bad++;
                $display("FAIL rand_pulse[%0d]: got v=%0d c=%0d expected v=%0d c=%0d", i,
                         (i < obs_q.size()) ? obs_q[i].v : -1, (i < obs_q.size()) ? obs_q[i].c : -1,
                         exp_q[i].v, exp_q[i].c);
            end
        end
        total++; if (hold_bad != 0 || lock_bad != 0) begin bad++; $display("FAIL rand_hold_lock: got hold=%0d lock=%0d expected 0", hold_bad, lock_bad); end
    endtask

    initial begin
        beat_pulse = 1'b0;
        f_beat     = 1'b0;
        test_reset();
        test_steady();
        test_averaging();
        test_debounce();
        test_boundary();
        test_timeout();
        test_overlap();
        test_reset_mid_divide();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
